// File: rtl/subn_fire_5in_if.sv
// Bus between the 5-input synapse/adder stage and the output soma.
// master drives sync/potential/learning controls; slave returns spike, potential, threshold and status.
interface subn_fire_5in_if #(
    parameter int unsigned W = 19
);
    logic [4:0]   i_sync;
    logic [W-1:0] i_s;
    logic         i_train;
    logic         i_miss;
    logic         o_spike;
    logic [W-1:0] o_potential;
    logic [W-1:0] o_thr;
    logic         o_busy;
    logic         o_drop;

    modport master (
        output i_sync, i_s, i_train, i_miss,
        input  o_spike, o_potential, o_thr, o_busy, o_drop
    );

    modport slave (
        input  i_sync, i_s, i_train, i_miss,
        output o_spike, o_potential, o_thr, o_busy, o_drop
    );
endinterface

// File: rtl/subn_fire_5in.sv
// Output soma of the 5-input sub-network: adaptive-threshold compare, one-cycle spike,
// refractory hold-off and ODESA-style threshold learning.
module subn_fire_5in #(
    parameter int unsigned p_width    = 8,
    parameter int unsigned p_shift    = 8,
    parameter int unsigned p_thr_init = 1000,
    parameter int unsigned p_thr_min  = 64,
    parameter int unsigned p_thr_step = 16,
    parameter int unsigned p_eta      = 2,
    parameter int unsigned p_refrac   = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    subn_fire_5in_if.slave bus
);
    localparam int unsigned W     = p_width + p_shift + 3;
    localparam int unsigned CNT_W = $clog2(p_refrac + 2);

    localparam logic [W-1:0] THR_INIT  = W'(p_thr_init);
    localparam logic [W-1:0] THR_MIN   = W'(p_thr_min);
    localparam logic [W-1:0] THR_STEP  = W'(p_thr_step);
    // Saturation test done on the floor so thr - step can never wrap.
    localparam logic [W-1:0] THR_FLOOR = W'(p_thr_min + p_thr_step);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_EVAL   = 3'd2;
    localparam logic [2:0] S_FIRE   = 3'd3;
    localparam logic [2:0] S_REFRAC = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [W-1:0]     r_s, r_s_nxt;
    logic [W-1:0]     thr, thr_nxt;
    logic             spike, spike_nxt;
    logic             busy, busy_nxt;
    logic             drop, drop_nxt;
    logic             fire_dec;
    logic             any_sync;

    assign any_sync = |bus.i_sync;

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            r_s   <= '0;
            thr   <= THR_INIT;
            spike <= 1'b0;
            busy  <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            r_s   <= r_s_nxt;
            thr   <= thr_nxt;
            spike <= spike_nxt;
            busy  <= busy_nxt;
            drop  <= drop_nxt;
        end
    end

    // Next-state, datapath and threshold learning.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        r_s_nxt   = r_s;
        thr_nxt   = thr;
        spike_nxt = 1'b0;
        drop_nxt  = 1'b0;
        fire_dec  = 1'b0;

        case (state)
            S_IDLE: begin
                if (any_sync) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                r_s_nxt   = bus.i_s;
                state_nxt = S_EVAL;
            end
            S_EVAL: begin
                if (r_s >= thr) begin
                    state_nxt = S_FIRE;
                    spike_nxt = 1'b1;
                    fire_dec  = 1'b1;
                    if (bus.i_train) thr_nxt = thr + ((r_s - thr) >> p_eta);
                end else if (any_sync) begin
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_FIRE: begin
                drop_nxt = any_sync;
                if (p_refrac == 0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt   = CNT_W'(p_refrac);
                    state_nxt = S_REFRAC;
                end
            end
            S_REFRAC: begin
                drop_nxt = any_sync;
                cnt_nxt  = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A fire decision owns the threshold that cycle, trained or not.
        if (bus.i_miss && !fire_dec) begin
            if (thr < THR_FLOOR) thr_nxt = THR_MIN;
            else                 thr_nxt = thr - THR_STEP;
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

    assign bus.o_spike     = spike;
    assign bus.o_potential = r_s;
    assign bus.o_thr       = thr;
    assign bus.o_busy      = busy;
    assign bus.o_drop      = drop;
endmodule

// File: tb/tb_subn_fire_5in.sv
// Directed bench for subn_fire_5in: latency, equality fire, refractory drop, threshold learning and reset.
module tb_subn_fire_5in;
    localparam int unsigned W = 19;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    subn_fire_5in_if #(.W(W)) bus ();

    subn_fire_5in dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Send one sync, then observe 25 cycles; optional extra sync / miss driven at cycle index c.
    task automatic run_event(input logic [4:0] s, input int sync_at, input logic [4:0] s2,
                             input int miss_at, output int busy_n, output int spk_n,
                             output int spk_at, output int drop_n, output int drop_at);
        busy_n = 0; spk_n = 0; spk_at = -1; drop_n = 0; drop_at = -1;
        bus.i_sync = s;
        step();
        for (int c = 1; c <= 25; c++) begin
            if (bus.o_busy) busy_n++;
            if (bus.o_spike) begin
                spk_n++;
                if (spk_at < 0) spk_at = c;
            end
            if (bus.o_drop) begin
                drop_n++;
                if (drop_at < 0) drop_at = c;
            end
            bus.i_sync = (c == sync_at) ? s2 : 5'd0;
            bus.i_miss = (c == miss_at);
            step();
        end
    endtask

    task automatic miss_pulse();
        bus.i_miss = 1'b1;
        step();
        bus.i_miss = 1'b0;
    endtask

    int bn, sn, sa, dn, da;

    initial begin
        rst_n       = 1'b0;
        bus.i_sync  = '0;
        bus.i_s     = '0;
        bus.i_train = 1'b0;
        bus.i_miss  = 1'b0;

        // Reset state
        apply_reset();
        check("rst_thr",   32'(bus.o_thr), 1000);
        check("rst_spike", 32'(bus.o_spike), 0);
        check("rst_pot",   32'(bus.o_potential), 0);
        check("rst_busy",  32'(bus.o_busy), 0);
        check("rst_drop",  32'(bus.o_drop), 0);

        // Trained fire, 3-edge latency, 11 busy cycles
        bus.i_s = 19'd1200; bus.i_train = 1'b1;
        run_event(5'b00001, 0, 5'd0, 0, bn, sn, sa, dn, da);
        check("t2_spk_at", sa, 3);
        check("t2_spk_n",  sn, 1);
        check("t2_busy_n", bn, 11);
        check("t2_pot",    32'(bus.o_potential), 1200);
        check("t2_thr",    32'(bus.o_thr), 1050);

        // Below threshold, then equality fire untrained
        apply_reset();
        bus.i_s = 19'd900;
        run_event(5'b10000, 0, 5'd0, 0, bn, sn, sa, dn, da);
        check("t3_nospk",  sn, 0);
        check("t3_busy_n", bn, 2);
        check("t3_pot",    32'(bus.o_potential), 900);
        check("t3_thr",    32'(bus.o_thr), 1000);
        bus.i_s = 19'd1000; bus.i_train = 1'b0;
        run_event(5'b10000, 0, 5'd0, 0, bn, sn, sa, dn, da);
        check("t3_eq_spk", sn, 1);
        check("t3_eq_at",  sa, 3);
        check("t3_eq_thr", 32'(bus.o_thr), 1000);

        // Sync in REFRAC cycle 3 dropped, no re-trigger
        bus.i_s = 19'd1100;
        run_event(5'b00001, 6, 5'b00100, 0, bn, sn, sa, dn, da);
        check("t4_drop_n",  dn, 1);
        check("t4_drop_at", da, 7);
        check("t4_spk_n",   sn, 1);
        check("t4_busy_n",  bn, 11);

        // Sync during EVAL below threshold -> WAIT again
        bus.i_s = 19'd500;
        run_event(5'b00001, 2, 5'b01000, 0, bn, sn, sa, dn, da);
        check("t4_reeval_busy", bn, 4);
        check("t4_reeval_spk",  sn, 0);
        check("t4_reeval_drop", dn, 0);

        // Walk threshold to 100: train 1000->1012, then 57 misses
        bus.i_s = 19'd1048; bus.i_train = 1'b1;
        run_event(5'b00001, 0, 5'd0, 0, bn, sn, sa, dn, da);
        check("t5_train", 32'(bus.o_thr), 1012);
        bus.i_train = 1'b0;
        for (int i = 0; i < 57; i++) miss_pulse();
        check("t5_thr100", 32'(bus.o_thr), 100);
        miss_pulse(); check("t5_miss1", 32'(bus.o_thr), 84);
        miss_pulse(); check("t5_miss2", 32'(bus.o_thr), 68);
        miss_pulse(); check("t5_miss3", 32'(bus.o_thr), 64);
        miss_pulse(); check("t5_miss4", 32'(bus.o_thr), 64);

        // Miss on the fire-decision edge: trained update only, untrained keeps thr
        bus.i_s = 19'd200; bus.i_train = 1'b1;
        run_event(5'b00010, 0, 5'd0, 2, bn, sn, sa, dn, da);
        check("t5_coinc_train", 32'(bus.o_thr), 98);
        bus.i_train = 1'b0;
        run_event(5'b00010, 0, 5'd0, 2, bn, sn, sa, dn, da);
        check("t5_coinc_notrain", 32'(bus.o_thr), 98);
        check("t5_coinc_spk", sn, 1);

        // Reset during REFRAC cycle 4
        bus.i_s = 19'd1200; bus.i_train = 1'b1;
        bus.i_sync = 5'b00001;
        step();
        bus.i_sync = 5'd0;
        for (int i = 0; i < 6; i++) step();
        check("t6_busy_pre", 32'(bus.o_busy), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_busy", 32'(bus.o_busy), 0);
        check("t6_thr",  32'(bus.o_thr), 1000);
        check("t6_pot",  32'(bus.o_potential), 0);
        bus.i_train = 1'b0;
        run_event(5'b00001, 0, 5'd0, 0, bn, sn, sa, dn, da);
        check("t6_spk_at",  sa, 3);
        check("t6_spk_n",   sn, 1);
        check("t6_busy_n",  bn, 11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
